// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, ten device-clocked
// frame bits, then ACK/NACK sampling, with an inter-edge timeout throughout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 480,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SHIFT, WAIT_ACK, WAIT_IDLE, DONE
  } state_e;

  state_e        state_q;
  logic [9:0]    frame_q;
  logic [IW-1:0] inh_cnt_q;
  logic [2:0]    rts_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [3:0]    bit_idx_q;
  logic          err_q;
  logic          clk_oe_q, data_oe_q, busy_q, done_q, error_q;
  logic [2:0]    clk_sync_q;
  logic [1:0]    data_sync_q;

  logic clk_s, data_s, fe;

  // Stage 2 is the synchronized level; stage 3 is its previous value for edge detection.
  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fe     = clk_sync_q[2] & ~clk_sync_q[1];

  // NOTE: every flop resets asynchronously and updates with <= so all state moves together on the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      inh_cnt_q <= '0;
      rts_cnt_q <= '0;
      tmo_cnt_q <= '0;
      bit_idx_q <= '0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_start) begin
            frame_q   <= {1'b1, ~^tx_data, tx_data};
            inh_cnt_q <= '0;
            rts_cnt_q <= '0;
            tmo_cnt_q <= '0;
            bit_idx_q <= '0;
            err_q     <= 1'b0;
            clk_oe_q  <= 1'b1;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt_q == INH_LAST) begin
            data_oe_q <= 1'b1;
            state_q   <= RTS;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end
        RTS: begin
          if (rts_cnt_q == 3'd7) begin
            clk_oe_q  <= 1'b0;
            bit_idx_q <= '0;
            tmo_cnt_q <= '0;
            state_q   <= SHIFT;
          end else begin
            rts_cnt_q <= rts_cnt_q + 1'b1;
          end
        end
        SHIFT, WAIT_ACK, WAIT_IDLE: begin
          // A stalled device wins over an edge arriving in the same cycle.
          if (tmo_cnt_q == TMO_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b1;
            error_q   <= 1'b1;
            state_q   <= DONE;
          end else begin
            tmo_cnt_q <= fe ? '0 : tmo_cnt_q + 1'b1;
            if (state_q == SHIFT && fe) begin
              bit_idx_q <= bit_idx_q + 1'b1;
              if (bit_idx_q == 4'd9) begin
                data_oe_q <= 1'b0;
                state_q   <= WAIT_ACK;
              end else begin
                data_oe_q <= ~frame_q[bit_idx_q];
              end
            end else if (state_q == WAIT_ACK && fe) begin
              err_q   <= data_s;
              state_q <= WAIT_IDLE;
            end else if (state_q == WAIT_IDLE && clk_s && data_s) begin
              done_q  <= 1'b1;
              error_q <= err_q;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          error_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a cycle-counted PS/2 device model on open-drain lines,
// checked against frames computed from the byte's bit count.
module tb_ps2_host_tx;

  localparam int INH = 480;
  localparam int TMO = 2000;
  localparam int H   = 160;  // device half period in clk cycles (12.5 kHz at 4 MHz)

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int exp_done = 0;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_data_i (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data LSB first, then an odd-parity bit, then the stop bit.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  // mode: 0 device ACKs, 1 device NACKs, 2 device silent, 3 reset after the 4th falling edge
  task automatic send_frame(input logic [7:0] d, input int hold, input int mode, input int pulse_at);
    logic [9:0] rx;
    logic [9:0] exp;
    int n;
    exp = model_frame(d);
    rx  = '0;
    @(negedge clk);
    check("done_count", done_cnt, exp_done);
    check("idle_busy", tx_busy, 0);
    check("idle_done", tx_done, 0);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    check("busy_after_start", tx_busy, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
      n++;
      if (n >= hold) tx_start = 1'b0;
      @(negedge clk);
    end
    tx_start = 1'b0;
    check("inhibit_len", n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("rts_len", n, 8);
    check("rts_release", {ps2_clk_oe, ps2_data_oe}, 2'b01);

    if (mode == 2) begin
      n = 0;
      while (!tx_done && n < TMO + 50) begin
        n++;
        @(negedge clk);
      end
      check("timeout_cycles", n, TMO);
      check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      check("timeout_err", tx_error, 1);
      check("timeout_busy", tx_busy, 1);
      exp_done++;
      return;
    end

    check("start_bit_seen", {ps2_clk_line, ps2_data_line}, 2'b10);
    repeat (H) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      if (k == 10) begin
        dev_data_low = (mode == 0);
        repeat (4) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (mode == 3 && k == 3) begin
        repeat (H / 2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("reset_busy", tx_busy, 0);
        check("reset_done", tx_done, 0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (k == pulse_at) begin
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (H - 1) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      dev_clk_low = 1'b0;
      if (k < 10) rx[k] = ps2_data_line;
      if (k == 10) dev_data_low = 1'b0;
      else repeat (H) @(negedge clk);
    end
    check("frame_bits", rx, exp);
    n = 0;
    while (!tx_done && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("done_seen", tx_done, 1);
    check("done_err", tx_error, (mode == 1) ? 1 : 0);
    check("busy_in_done", tx_busy, 1);
    exp_done++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 5'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(8'hF4, 1, 0, -1);
    send_frame(8'h00, 1, 0, -1);
    send_frame(8'hFF, 1, 0, -1);
    send_frame(8'h01, 1, 0, -1);
    send_frame(8'hA5, 1, 1, -1);
    send_frame(8'h3C, 1, 2, -1);
    send_frame(8'h55, 1, 3, -1);
    send_frame(8'hED, 1, 0, -1);
    send_frame(8'h9A, 3, 0, 5);
    repeat (30) @(negedge clk);
    check("no_second_frame_busy", tx_busy, 0);
    check("no_second_frame_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    for (int r = 0; r < 5; r++) begin
      logic [7:0] d;
      int m;
      d = 8'($urandom);
      m = int'($urandom_range(0, 1));
      send_frame(d, 1, m, -1);
    end
    repeat (5) @(negedge clk);
    check("final_done_count", done_cnt, exp_done);
    check("final_idle", {tx_busy, ps2_clk_oe, ps2_data_oe}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
